// File: rtl/mips_imem_loader.sv
// Instruction-memory loader: turns a length-prefixed host byte stream into big-endian
// word writes at addresses 0..N-1 and holds the core until the image is complete.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module mips_imem_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
  // byte_ready depends only on registered state, never on byte_valid.
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
    S_DONE = 3'd4, S_ERR = 3'd5, S_CHK = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
    S_DONE = 3'd4, S_ERR = 3'd5
  } state_t;
`endif

  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(2**ADDR_W);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          chk_q, chk_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                ready_c;
  logic                last_write;

  // The final word's write cycle closes the data phase; no byte is taken during it.
  assign last_write = mem_we_q && (LEN_W'(word_idx_q) == len_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    shift_d     = shift_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready_c     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
          word_idx_d = '0;
          shift_d    = '0;
          chk_d      = '0;
        end
      end
      S_LEN_HI: begin
        ready_c = 1'b1;
        if (byte_valid) begin
          len_d   = {byte_in, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        ready_c = 1'b1;
        if (byte_valid) begin
          len_d = {len_q[15:8], byte_in};
          if (len_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_d} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_write) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          ready_c = 1'b1;
          if (byte_valid) begin
            shift_d    = {shift_q[15:0], byte_in};
            chk_d      = chk_q ^ byte_in;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_idx_q[ADDR_W-1:0];
              mem_wdata_d = {shift_q, byte_in};
              word_idx_d  = word_idx_q + (ADDR_W+1)'(1);
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        ready_c = 1'b1;
        if (byte_valid) state_d = (byte_in == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      shift_q     <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      shift_q     <= shift_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign byte_ready = ready_c;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign core_hold  = (state_q != S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Self-checking bench for mips_imem_loader: directed frame table, hand-written
// corner sequences and randomized frames scored against an expected-write queue.
module tb_mips_imem_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, mem_we, core_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        dbg_state;

  mips_imem_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_hold(core_hold),
    .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [31:0] frame_w [0:1023];

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    logic        exp_done;
    logic        exp_err;
  } vec_t;
  vec_t tbl [0:6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {mem_addr, mem_wdata}, mon_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_in = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got byte_ready low for %0d cycles expected high", n);
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 30) begin
      step();
      n++;
    end
    if (n == 30) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: got neither done nor error after %0d cycles expected one", n);
    end
  endtask

  // Reference: header is N big-endian, then each word MSB first; word i lands at address i.
  task automatic run_frame(input int n, input int max_stall, input logic exp_done, input logic exp_err);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    pulse_start();
    send_byte(8'(n / 256));
    send_byte(8'(n % 256));
    if (n <= 1024) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'((frame_w[i] >> (24 - 8 * k)) % 256);
          x = x ^ b;
          repeat ($urandom_range(0, max_stall)) step();
          if (k == 3) exp_q.push_back({ADDR_W'(i), frame_w[i]});
          send_byte(b);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x);
`endif
    end
    wait_end();
    step();
    chk("frame_done", done, exp_done);
    chk("frame_error", error, exp_err);
    chk("frame_hold", core_hold, !exp_done);
    chk("frame_ready", byte_ready, 1'b0);
    chk("frame_pending", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] two_word [0:9];
    int c0;
    two_word[0] = 8'h00; two_word[1] = 8'h02; two_word[2] = 8'h20; two_word[3] = 8'h01;
    two_word[4] = 8'h00; two_word[5] = 8'h05; two_word[6] = 8'hFC; two_word[7] = 8'h00;
    two_word[8] = 8'h00; two_word[9] = 8'h00;

    tbl[0] = '{2,    32'h20010005, 32'hFC000000, 0, 1'b1, 1'b0};
    tbl[1] = '{0,    32'h0,        32'h0,        0, 1'b1, 1'b0};
    tbl[2] = '{1025, 32'h0,        32'h0,        0, 1'b0, 1'b1};
    tbl[3] = '{1,    32'h12345678, 32'h0,        1, 1'b1, 1'b0};
    tbl[4] = '{1024, 32'hDEADBEEF, 32'h01020304, 0, 1'b1, 1'b0};
    tbl[5] = '{1,    32'h00000000, 32'h0,        3, 1'b1, 1'b0};
    tbl[6] = '{3,    32'hFFFFFFFF, 32'h80000001, 2, 1'b1, 1'b0};

    // Reset and idle
    repeat (3) step();
    chk("rst_hold", core_hold, 1'b1);
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    repeat (4) step();
    byte_valid = 1'b0;
    chk("idle_hold", core_hold, 1'b1);
    chk("idle_done", done, 1'b0);
    chk("idle_error", error, 1'b0);
    chk("idle_ready", byte_ready, 1'b0);

    // Two-word frame at full rate with exact write and done timing
    exp_q.push_back({10'd0, 32'h20010005});
    exp_q.push_back({10'd1, 32'hFC000000});
    pulse_start();
    c0 = cyc;
    for (int i = 0; i < 10; i++) send_byte(two_word[i]);
    chk("full_rate_cycles", cyc - c0, 10);
    chk("last_we", mem_we, 1'b1);
    chk("last_addr", mem_addr, 10'd1);
    chk("last_wdata", mem_wdata, 32'hFC000000);
    chk("last_not_done", done, 1'b0);
    chk("last_ready", byte_ready, 1'b0);
    step();
`ifndef LOADER_CHECKSUM_EN
    chk("done_after_write", done, 1'b1);
    chk("hold_after_write", core_hold, 1'b0);
`else
    send_byte(8'h20 ^ 8'h01 ^ 8'h05 ^ 8'hFC);
    chk("done_after_chk", done, 1'b1);
`endif
    chk("we_single", mem_we, 1'b0);

    // Restart from DONE raises core_hold on the next edge
    pulse_start();
    chk("restart_hold", core_hold, 1'b1);
    chk("restart_done", done, 1'b0);
    chk("restart_ready", byte_ready, 1'b1);

    // Same frame with a 5-cycle stall between the 2nd and 3rd data bytes
    exp_q.push_back({10'd0, 32'h20010005});
    exp_q.push_back({10'd1, 32'hFC000000});
    for (int i = 0; i < 4; i++) send_byte(two_word[i]);
    for (int i = 0; i < 5; i++) begin
      chk("stall_no_we", mem_we, 1'b0);
      step();
    end
    for (int i = 4; i < 10; i++) send_byte(two_word[i]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h20 ^ 8'h01 ^ 8'h05 ^ 8'hFC);
`endif
    wait_end();
    chk("stall_done", done, 1'b1);
    chk("stall_pending", exp_q.size(), 0);

    // start during DATA is ignored
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    pulse_start();
    chk("data_start_ready", byte_ready, 1'b1);
    chk("data_start_hold", core_hold, 1'b1);
    exp_q.push_back({10'd0, 32'hABCDEF01});
    send_byte(8'hEF);
    send_byte(8'h01);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAB ^ 8'hCD ^ 8'hEF ^ 8'h01);
`endif
    wait_end();
    chk("data_start_done", done, 1'b1);
    chk("data_start_pending", exp_q.size(), 0);

    // Directed frame table
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 1024; i++) frame_w[i] = $urandom;
      frame_w[0] = tbl[t].w0;
      frame_w[1] = tbl[t].w1;
      run_frame(tbl[t].n, tbl[t].stall, tbl[t].exp_done, tbl[t].exp_err);
    end

    // Randomized frames
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) frame_w[i] = $urandom;
      run_frame(n, $urandom_range(0, 3), 1'b1, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    exp_q.push_back({10'd0, 32'h12345678});
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h08);
    chk("chk_good_done", done, 1'b1);
    exp_q.push_back({10'd0, 32'h12345678});
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    chk("chk_bad_error", error, 1'b1);
    chk("chk_bad_hold", core_hold, 1'b1);
    chk("chk_bad_pending", exp_q.size(), 0);
`endif

    // Reset in the middle of a load
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", byte_ready, 1'b0);
    chk("midrst_hold", core_hold, 1'b1);
    chk("midrst_addr", mem_addr, '0);
    chk("midrst_wdata", mem_wdata, '0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_error", error, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_idle_ready", byte_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
